boid_frame_plotter: RTL and testbench
=====================================

# boid_frame_plotter

Per-frame sequencer that rasterises all boid positions into the 1-bit boid display RAM. On each end-of-screen pulse from the VGA controller it clears the display RAM, then walks the BPU array one boid at a time. For each boid it latches (x, y) through the boid-select mux and issues one RAM write per pixel of a small square sprite. It sits between the BPU array and the display RAM, which is read by the VGA controller, and replaces the ad-hoc counter logic at top level.

## Interface
- NUM_BOIDS, 8, number of BPUs scanned per frame (≥1)
- BOID_IDX_W, 3, width of boid_sel, = clog2(NUM_BOIDS), min 1
- SPRITE_SIZE, 2, side length in pixels of drawn square (1..4)
- VIDEO_WIDTH, 640, active pixels per line
- VIDEO_HEIGHT, 480, active lines
- ADDR_WIDTH, 19, display RAM address width

Ports:
- clock  in  1  system clock (50 MHz domain)
- reset  in  1  asynchronous, active-high
- frame_end  in  1  one-cycle pulse, synchronous to clock (VGA screenEnd_out)
- boid_sel  out  BOID_IDX_W  index driving the BPU one-hot select / tristate mux
- boid_x  in  10  x of selected boid, valid one cycle after boid_sel changes
- boid_y  in  9  y of selected boid, same timing as boid_x
- fb_clear  out  1  one-cycle pulse; clears/switches the display RAM (RAM reset input)
- fb_we  out  1  display RAM write enable (write data is constant 1)
- fb_addr  out  ADDR_WIDTH  display RAM write address
- busy  out  1  high from frame acceptance until the frame completes
- frame_count  out  16  completed frames, wraps 65535→0
- overrun  out  1  sticky; set when frame_end arrives while not IDLE

## Operation
- FSM states: IDLE, CLEAR, LATCH, DRAW, DONE.
- IDLE
  - busy=0.
  - frame_end=1 → CLEAR, boid_sel←0.
- CLEAR
  - Lasts 1 cycle; fb_clear=1 for exactly this cycle.
  - Goes to LATCH.
- LATCH
  - Lasts 1 cycle; boid_sel is stable for the whole cycle.
  - At the cycle's end edge, bx←boid_x, by←boid_y, dx←0, dy←0.
  - Goes to DRAW.
- DRAW
  - Lasts SPRITE_SIZE² cycles, one per pixel (px=bx+dx, py=by+dy).
  - dx increments fastest; it wraps to 0 and dy increments.
  - Pixel is in bounds iff px<VIDEO_WIDTH and py<VIDEO_HEIGHT, computed with widened adders so there is no wrap.
  - In bounds: the registered outputs load fb_we=1, fb_addr=py·VIDEO_WIDTH+px.
  - Out of bounds: fb_we=0; the slot still consumes its cycle.
  - After the last pixel: if boid_sel==NUM_BOIDS−1 → DONE, else boid_sel+1 → LATCH.
- DONE
  - Lasts 1 cycle; frame_count+1.
  - Goes to IDLE.
- frame_end outside IDLE (CLEAR, LATCH, DRAW, DONE) is ignored and sets overrun. The current frame is not restarted.

## Timing
- Reset values: state=IDLE, boid_sel=0, fb_clear=0, fb_we=0, fb_addr=0, busy=0, frame_count=0, overrun=0, internal bx/by/dx/dy=0.
- Reset mid-frame aborts immediately. No further writes or clears occur until the next accepted frame_end.
- Edge 0 samples frame_end in IDLE:
  - fb_clear=1 and busy=1 during cycle 1.
  - Cycle 2 is the LATCH cycle for boid 0.
- fb_we/fb_addr are registered. A pixel processed in DRAW cycle n is presented in cycle n+1.
- Boid b's first DRAW cycle is 3+b·(1+S²), with S=SPRITE_SIZE.
- The last write is presented during DONE. busy drops the cycle after DONE.
- Frame length (frame_end edge to busy low) = 2 + NUM_BOIDS·(1+S²) + 1 cycles. With defaults this is 43, far below the vertical blanking interval.
- fb_we is never high in the same cycle as fb_clear.
- Address arithmetic:
  - y·640 is implemented as (y<<9)+(y<<7).
  - Max address 307199 fits in 19 bits.

## Structure
- Shared header boid_params.vh holds VIDEO_WIDTH, VIDEO_HEIGHT, PIXEL_COUNT, ADDR_WIDTH, and the FSM state encodings. The top level and the VGA controller include the same header.
- Sub-module pixel_addr_calc (combinational)
  - Inputs: bx, by, dx, dy.
  - Outputs: addr and in_bounds flag.
- The FSM, counters and output registers live in boid_frame_plotter.

## Test plan
- **Single frame, defaults:** boid 0 at (10,20), others at (100,100); one frame_end pulse.
  - fb_clear is high exactly one cycle.
  - Boid 0 writes 12810, 12811, 13450, 13451 in order.
  - 32 writes total; busy low 43 cycles after the pulse; frame_count=1.
- **Edge clipping:** boid at (639,479).
  - Only address 307199 is written; the other 3 slots have fb_we=0.
  - Timing is unchanged.
- **Out-of-range input:** boid_x=1000, boid_y=500.
  - No fb_we for that boid; the remaining boids are drawn normally.
- **Overrun:** second frame_end 10 cycles after the first.
  - The frame completes normally; overrun=1 and stays set.
  - frame_count=1.
- **Reset mid-DRAW:** assert reset during boid 3's DRAW.
  - All outputs return to reset values at once; no writes afterwards.
  - The next frame_end runs a full correct frame.
- **Wrap:** preload or run 65536 frames.
  - frame_count wraps to 0.

Source files
------------

// File: rtl/boid_frame_plotter_pkg.sv
// Shared display geometry, coordinate widths and sequencer state encoding for the boid plotter
// and the VGA side that reads the same display RAM.
package boid_frame_plotter_pkg;

  localparam int unsigned VideoWidth  = 640;
  localparam int unsigned VideoHeight = 480;
  localparam int unsigned PixelCount  = VideoWidth * VideoHeight;
  localparam int unsigned AddrWidth   = 19;

  // BPU coordinate widths and the widened pixel widths that cannot wrap after adding dx/dy.
  localparam int unsigned CoordXW = 10;
  localparam int unsigned CoordYW = 9;
  localparam int unsigned PxW     = CoordXW + 1;
  localparam int unsigned PyW     = CoordYW + 1;
  localparam int unsigned DeltaW  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StLatch,
    StDraw,
    StDone
  } plot_state_e;

endpackage

// File: rtl/pixel_addr_calc.sv
// Combinational sprite pixel position, on-screen test and row-major display RAM address.
module pixel_addr_calc
  import boid_frame_plotter_pkg::*;
#(
  parameter int unsigned VIDEO_WIDTH  = VideoWidth,
  parameter int unsigned VIDEO_HEIGHT = VideoHeight,
  parameter int unsigned ADDR_WIDTH   = AddrWidth
) (
  input  logic [CoordXW-1:0]    bx_i,
  input  logic [CoordYW-1:0]    by_i,
  input  logic [DeltaW-1:0]     dx_i,
  input  logic [DeltaW-1:0]     dy_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  in_bounds_o
);

  localparam logic [PxW-1:0] XLimit = PxW'(VIDEO_WIDTH);
  localparam logic [PyW-1:0] YLimit = PyW'(VIDEO_HEIGHT);

  logic [PxW-1:0]        px;
  logic [PyW-1:0]        py;
  logic [ADDR_WIDTH-1:0] row_base;

  assign px = PxW'(bx_i) + PxW'(dx_i);
  assign py = PyW'(by_i) + PyW'(dy_i);

  assign in_bounds_o = (px < XLimit) && (py < YLimit);

  if (VIDEO_WIDTH == 640) begin : g_shift
    // 640 = 512 + 128, so the row base needs only one adder.
    assign row_base = (ADDR_WIDTH'(py) << 9) + (ADDR_WIDTH'(py) << 7);
  end else begin : g_mul
    assign row_base = ADDR_WIDTH'(py) * ADDR_WIDTH'(VIDEO_WIDTH);
  end

  assign addr_o = row_base + ADDR_WIDTH'(px);

endmodule

// File: rtl/boid_frame_plotter.sv
// Per-frame sequencer: clears the 1-bit display RAM, then walks every BPU and writes a small
// square sprite at each boid position.
module boid_frame_plotter
  import boid_frame_plotter_pkg::*;
#(
  parameter int unsigned NUM_BOIDS    = 8,
  parameter int unsigned BOID_IDX_W   = 3,
  parameter int unsigned SPRITE_SIZE  = 2,
  parameter int unsigned VIDEO_WIDTH  = VideoWidth,
  parameter int unsigned VIDEO_HEIGHT = VideoHeight,
  parameter int unsigned ADDR_WIDTH   = AddrWidth
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  frame_end,
  output logic [BOID_IDX_W-1:0] boid_sel,
  input  logic [CoordXW-1:0]    boid_x,
  input  logic [CoordYW-1:0]    boid_y,
  output logic                  fb_clear,
  output logic                  fb_we,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  output logic                  busy,
  output logic [15:0]           frame_count,
  output logic                  overrun
);

  localparam logic [BOID_IDX_W-1:0] LastBoid  = BOID_IDX_W'(NUM_BOIDS - 1);
  localparam logic [DeltaW-1:0]     LastDelta = DeltaW'(SPRITE_SIZE - 1);

  plot_state_e           state_q;
  logic [BOID_IDX_W-1:0] boid_sel_q;
  logic [CoordXW-1:0]    bx_q;
  logic [CoordYW-1:0]    by_q;
  logic [DeltaW-1:0]     dx_q;
  logic [DeltaW-1:0]     dy_q;
  logic                  fb_clear_q;
  logic                  fb_we_q;
  logic [ADDR_WIDTH-1:0] fb_addr_q;
  logic [15:0]           frame_count_q;
  logic                  overrun_q;

  logic [ADDR_WIDTH-1:0] pix_addr;
  logic                  pix_in_bounds;

  pixel_addr_calc #(
    .VIDEO_WIDTH (VIDEO_WIDTH),
    .VIDEO_HEIGHT(VIDEO_HEIGHT),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_pixel_addr_calc (
    .bx_i       (bx_q),
    .by_i       (by_q),
    .dx_i       (dx_q),
    .dy_i       (dy_q),
    .addr_o     (pix_addr),
    .in_bounds_o(pix_in_bounds)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      boid_sel_q    <= '0;
      bx_q          <= '0;
      by_q          <= '0;
      dx_q          <= '0;
      dy_q          <= '0;
      fb_clear_q    <= 1'b0;
      fb_we_q       <= 1'b0;
      fb_addr_q     <= '0;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      fb_clear_q <= 1'b0;
      fb_we_q    <= 1'b0;
      // A frame already in flight is never restarted; late pulses are only recorded.
      if (frame_end && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (frame_end) begin
            state_q    <= StClear;
            boid_sel_q <= '0;
            fb_clear_q <= 1'b1;
          end
        end
        StClear: begin
          state_q <= StLatch;
        end
        StLatch: begin
          bx_q    <= boid_x;
          by_q    <= boid_y;
          dx_q    <= '0;
          dy_q    <= '0;
          state_q <= StDraw;
        end
        StDraw: begin
          // Clipped pixels still take their slot so frame timing is position independent.
          fb_we_q <= pix_in_bounds;
          if (pix_in_bounds) begin
            fb_addr_q <= pix_addr;
          end
          if (dx_q == LastDelta) begin
            dx_q <= '0;
            if (dy_q == LastDelta) begin
              dy_q <= '0;
              if (boid_sel_q == LastBoid) begin
                state_q <= StDone;
              end else begin
                boid_sel_q <= boid_sel_q + 1'b1;
                state_q    <= StLatch;
              end
            end else begin
              dy_q <= dy_q + 1'b1;
            end
          end else begin
            dx_q <= dx_q + 1'b1;
          end
        end
        StDone: begin
          frame_count_q <= frame_count_q + 1'b1;
          state_q       <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign boid_sel    = boid_sel_q;
  assign fb_clear    = fb_clear_q;
  assign fb_we       = fb_we_q;
  assign fb_addr     = fb_addr_q;
  assign busy        = (state_q != StIdle);
  assign frame_count = frame_count_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_boid_frame_plotter.sv
// Self-checking bench for boid_frame_plotter: table of boid-0 positions plus overrun and
// mid-frame reset sequences, with a scoreboard of expected RAM writes.
module tb_boid_frame_plotter;

  localparam int NB = 8;
  localparam int S  = 2;

  logic        clock;
  logic        reset;
  logic        frame_end;
  logic [2:0]  boid_sel;
  logic [9:0]  boid_x;
  logic [8:0]  boid_y;
  logic        fb_clear;
  logic        fb_we;
  logic [18:0] fb_addr;
  logic        busy;
  logic [15:0] frame_count;
  logic        overrun;

  boid_frame_plotter dut (
    .clock      (clock),
    .reset      (reset),
    .frame_end  (frame_end),
    .boid_sel   (boid_sel),
    .boid_x     (boid_x),
    .boid_y     (boid_y),
    .fb_clear   (fb_clear),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .busy       (busy),
    .frame_count(frame_count),
    .overrun    (overrun)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  // BPU array model: the selected boid's coordinates settle within the cycle.
  logic [9:0] pos_x [NB];
  logic [8:0] pos_y [NB];
  assign boid_x = pos_x[boid_sel];
  assign boid_y = pos_y[boid_sel];

  typedef struct {
    int addr;
    int cyc;
  } wr_t;

  typedef struct {
    int x0;
    int y0;
    int b0_writes;
  } vec_t;

  wr_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;
  int  cyc    = 0;
  int  t0     = 0;
  int  wr_cnt = 0;
  int  clr_cnt = 0;
  int  exp_fc = 0;
  bit  mon_en = 1'b0;

  always @(posedge clock) cyc = cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    int  cidx;
    wr_t e;
    if (mon_en) begin
      cidx = cyc - t0;
      if (fb_clear) begin
        clr_cnt++;
        check("clear_cycle", cidx, 1);
      end
      if (fb_we) begin
        wr_cnt++;
        check("we_with_clear", fb_clear, 0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL extra_write: addr %0d at cycle %0d, none expected", fb_addr, cidx);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", fb_addr, e.addr);
          check("wr_cycle", cidx, e.cyc);
        end
      end
    end
  end

  task automatic build_model();
    wr_t w;
    int  px, py;
    exp_q.delete();
    for (int b = 0; b < NB; b++) begin
      for (int dy = 0; dy < S; dy++) begin
        for (int dx = 0; dx < S; dx++) begin
          px = int'(pos_x[b]) + dx;
          py = int'(pos_y[b]) + dy;
          if (px < 640 && py < 480) begin
            w.addr = py * 640 + px;
            w.cyc  = 3 + b * (1 + S * S) + dy * S + dx + 1;
            exp_q.push_back(w);
          end
        end
      end
    end
  endtask

  // One frame from a frame_end pulse to busy low; ovr_at>0 injects a second pulse then.
  task automatic run_frame(input string tag, input int b0_writes, input int ovr_at,
                           input int exp_ovr);
    int cidx;
    build_model();
    wr_cnt  = 0;
    clr_cnt = 0;
    @(negedge clock);
    frame_end = 1'b1;
    t0 = cyc;
    mon_en = 1'b1;
    cidx = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      cidx = cyc - t0;
      frame_end = (ovr_at != 0) && (cidx == ovr_at);
      if (!busy) break;
    end
    check({tag, "_frame_len"}, cidx, 43);
    @(negedge clock);
    mon_en = 1'b0;
    exp_fc++;
    check({tag, "_clear_count"}, clr_cnt, 1);
    check({tag, "_write_count"}, wr_cnt, 28 + b0_writes);
    check({tag, "_pending_writes"}, exp_q.size(), 0);
    check({tag, "_frame_count"}, frame_count, exp_fc);
    check({tag, "_overrun"}, overrun, exp_ovr);
    check({tag, "_busy_idle"}, busy, 0);
  endtask

  vec_t vecs[8];
  int   quiet_bad;

  initial begin
    vecs[0] = '{10, 20, 4};
    vecs[1] = '{639, 479, 1};
    vecs[2] = '{1000, 500, 0};
    vecs[3] = '{640, 0, 0};
    vecs[4] = '{0, 480, 0};
    vecs[5] = '{638, 478, 4};
    vecs[6] = '{1023, 511, 0};
    vecs[7] = '{0, 0, 4};
    for (int b = 0; b < NB; b++) begin
      pos_x[b] = 10'(100 + b * 20);
      pos_y[b] = 9'(100 + b * 10);
    end

    reset = 1'b1;
    frame_end = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_boid_sel", boid_sel, 0);
    check("rst_fb_clear", fb_clear, 0);
    check("rst_fb_we", fb_we, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 8; i++) begin
      pos_x[0] = 10'(vecs[i].x0);
      pos_y[0] = 9'(vecs[i].y0);
      run_frame($sformatf("vec%0d", i), vecs[i].b0_writes, 0, 0);
      repeat (3) @(negedge clock);
    end

    pos_x[0] = 10'd10;
    pos_y[0] = 9'd20;
    run_frame("overrun", 4, 10, 1);
    repeat (3) @(negedge clock);
    run_frame("overrun_sticky", 4, 0, 1);

    // Reset during boid 3's sprite (DRAW cycles 18..21).
    @(negedge clock);
    frame_end = 1'b1;
    t0 = cyc;
    @(negedge clock);
    frame_end = 1'b0;
    repeat (18) @(negedge clock);
    check("pre_reset_sel", boid_sel, 3);
    check("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_boid_sel", boid_sel, 0);
    check("mid_rst_fb_we", fb_we, 0);
    check("mid_rst_fb_addr", fb_addr, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_frame_count", frame_count, 0);
    check("mid_rst_overrun", overrun, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    quiet_bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (fb_we || fb_clear || busy) quiet_bad++;
    end
    check("post_reset_quiet", quiet_bad, 0);
    exp_fc = 0;
    run_frame("after_reset", 4, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
